// File: rtl/cpu_bus_target.sv
// Memory-side responder for the CPU bus: word RAM plus an MMIO page holding a
// TX byte FIFO, a free-running cycle counter with snapshot, and an LED register.
module cpu_bus_target #(
    parameter int RAM_AWIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_raddr_i,
    input  logic        mem_rd_i,
    output logic [15:0] mem_rdata_o,
    input  logic [15:0] mem_waddr_i,
    input  logic [15:0] mem_wdata_i,
    input  logic        mem_wr_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic [7:0]  led_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [15:0]      ram [2**RAM_AWIDTH];
    logic [7:0]       fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic [31:0]      counter;
    logic [15:0]      snapshot;
    logic [7:0]       led;

    function automatic logic is_ram(input logic [15:0] a);
        return (a >> RAM_AWIDTH) == 16'd0;
    endfunction

    // IO registers live at 0xFF00..0xFF07; the rest of the page is unmapped.
    function automatic logic is_io(input logic [15:0] a, input logic [2:0] sel);
        return a == {13'h1FE0, sel};
    endfunction

    logic full, empty, pop, push_req, push_ok, ovf_set, ovf_clr, snap_ld, led_wr;
    logic [15:0] status, rd_val;

    assign full     = count == CNT_W'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign pop      = !empty && tx_ready_i;
    assign push_req = mem_wr_i && is_io(mem_waddr_i, 3'd0);
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = mem_wr_i && is_io(mem_waddr_i, 3'd1) && mem_wdata_i[2];
    assign snap_ld  = mem_rd_i && is_io(mem_raddr_i, 3'd2);
    assign led_wr   = mem_wr_i && is_io(mem_waddr_i, 3'd4);

    always_comb begin
        status             = '0;
        status[0]          = full;
        status[1]          = empty;
        status[2]          = ovf;
        status[3 +: CNT_W] = count;
    end

    // Read mux sees only pre-edge state, which gives read-before-write for free.
    always_comb begin
        rd_val = '0;
        if (is_ram(mem_raddr_i)) begin
            rd_val = ram[mem_raddr_i[RAM_AWIDTH-1:0]];
        end else if (mem_raddr_i[15:3] == 13'h1FE0) begin
            case (mem_raddr_i[2:0])
                3'd0, 3'd1: rd_val = status;
                3'd2:       rd_val = counter[15:0];
                3'd3:       rd_val = snapshot;
                3'd4:       rd_val = {8'h00, led};
                default:    rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr_i && is_ram(mem_waddr_i)) begin
            ram[mem_waddr_i[RAM_AWIDTH-1:0]] <= mem_wdata_i;
        end
        if (push_ok) begin
            fifo[wr_ptr] <= mem_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata_o <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            counter     <= '0;
            snapshot    <= '0;
            led         <= '0;
        end else begin
            if (mem_rd_i) begin
                mem_rdata_o <= rd_val;
            end
            if (snap_ld) begin
                snapshot <= counter[31:16];
            end
            counter <= counter + 32'd1;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (led_wr) begin
                led <= mem_wdata_i[7:0];
            end
        end
    end

    assign tx_valid_o = !empty;
    assign tx_data_o  = empty ? 8'h00 : fifo[rd_ptr];
    assign led_o      = led;

endmodule

// File: tb/tb_cpu_bus_target.sv
// Bench for cpu_bus_target: directed scenarios plus random bus traffic, all
// compared against a transaction-level model (array RAM, byte queue, counter).
module tb_cpu_bus_target;
    localparam int RAM_AWIDTH = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int RAM_WORDS  = 1 << RAM_AWIDTH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_raddr_i;
    logic        mem_rd_i;
    logic [15:0] mem_rdata_o;
    logic [15:0] mem_waddr_i;
    logic [15:0] mem_wdata_i;
    logic        mem_wr_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic [7:0]  led_o;

    cpu_bus_target #(.RAM_AWIDTH(RAM_AWIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_raddr_i(mem_raddr_i), .mem_rd_i(mem_rd_i), .mem_rdata_o(mem_rdata_o),
        .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i), .mem_wr_i(mem_wr_i),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .led_o(led_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_ram [RAM_WORDS];
    logic [7:0]  m_q [$];
    logic        m_ovf;
    logic [31:0] m_cnt;
    logic [15:0] m_snap;
    logic [7:0]  m_led;
    logic [15:0] m_rdata;
    logic        rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        logic [15:0] st;
        st = {9'd0, 4'(m_q.size()), m_ovf, m_q.size() == 0, m_q.size() == FIFO_DEPTH};
        if (a < RAM_WORDS) return m_ram[a[RAM_AWIDTH-1:0]];
        if (a >= 16'hFF00 && a <= 16'hFF07) begin
            case (a[2:0])
                3'd0, 3'd1: return st;
                3'd2:       return m_cnt[15:0];
                3'd3:       return m_snap;
                3'd4:       return {8'h00, m_led};
                default:    return 16'h0000;
            endcase
        end
        return 16'h0000;
    endfunction

    function automatic void m_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_cnt   = '0;
        m_snap  = '0;
        m_led   = '0;
        m_rdata = '0;
    endfunction

    // One bus cycle: drive, advance the model, clock, then compare all outputs.
    task automatic step(input logic [15:0] ra, input logic rd, input logic [15:0] wa,
                        input logic [15:0] wd, input logic wr);
        logic [15:0] rv;
        logic        pop, full;
        mem_raddr_i = ra; mem_rd_i = rd; mem_waddr_i = wa;
        mem_wdata_i = wd; mem_wr_i = wr; tx_ready_i = rdy;
        rv   = m_read(ra);
        full = m_q.size() == FIFO_DEPTH;
        pop  = m_q.size() != 0 && rdy;
        if (pop) void'(m_q.pop_front());
        if (wr) begin
            if (wa == 16'hFF00) begin
                if (!full || pop) m_q.push_back(wd[7:0]);
                else m_ovf = 1'b1;
            end else if (wa == 16'hFF01) begin
                if (wd[2]) m_ovf = 1'b0;
            end else if (wa == 16'hFF04) begin
                m_led = wd[7:0];
            end else if (wa < RAM_WORDS) begin
                m_ram[wa[RAM_AWIDTH-1:0]] = wd;
            end
        end
        if (rd && ra == 16'hFF02) m_snap = m_cnt[31:16];
        if (rd) m_rdata = rv;
        m_cnt = m_cnt + 32'd1;
        @(posedge clk);
        #1;
        check("rdata", mem_rdata_o, m_rdata);
        check("tx_valid", tx_valid_o, m_q.size() != 0);
        check("tx_data", tx_data_o, (m_q.size() != 0) ? m_q[0] : 8'h00);
        check("led", led_o, m_led);
    endtask

    task automatic bus_rd(input logic [15:0] a);
        step(a, 1'b1, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        step(16'h0000, 1'b0, a, d, 1'b1);
    endtask

    task automatic bus_idle();
        step(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 5))
            0, 1:    return 16'($urandom_range(0, 31));
            2:       return 16'hFF00 | 16'($urandom_range(0, 7));
            3:       return 16'hFF00;
            4:       return 16'hFF01;
            default: return ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'hFF10;
        endcase
    endfunction

    logic [15:0] lo, ra, wa;
    logic [31:0] exp_cnt;

    initial begin
        rst_n = 1'b0;
        mem_raddr_i = '0; mem_rd_i = 1'b0; mem_waddr_i = '0;
        mem_wdata_i = '0; mem_wr_i = 1'b0; tx_ready_i = 1'b0;
        rdy = 1'b0;
        m_reset();
        #12;
        check("rst_rdata", mem_rdata_o, 16'h0000);
        check("rst_valid", tx_valid_o, 1'b0);
        check("rst_data", tx_data_o, 8'h00);
        check("rst_led", led_o, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) bus_wr(16'(a), 16'($urandom));
        bus_wr(16'h0000, 16'h1111);

        // RAM write/read and read-before-write
        bus_wr(16'h0010, 16'hBEEF);
        bus_rd(16'h0010);
        check("ram_rd", mem_rdata_o, 16'hBEEF);
        step(16'h0010, 1'b1, 16'h0010, 16'h1234, 1'b1);
        check("rbw_old", mem_rdata_o, 16'hBEEF);
        bus_rd(16'h0010);
        check("rbw_new", mem_rdata_o, 16'h1234);

        // Unmapped space
        bus_rd(16'h8000);
        check("unmap_8000", mem_rdata_o, 16'h0000);
        bus_rd(16'h0000);
        bus_rd(16'hFF10);
        check("unmap_ff10", mem_rdata_o, 16'h0000);
        bus_wr(16'h8000, 16'hDEAD);
        bus_rd(16'h8000);
        check("unmap_wr", mem_rdata_o, 16'h0000);
        bus_rd(16'h0000);
        check("ram_intact", mem_rdata_o, 16'h1111);

        // FIFO fill, overflow, drain, clear
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) bus_wr(16'hFF00, 16'h0041 + 16'(i));
        bus_rd(16'hFF01);
        check("st_full", mem_rdata_o, 16'h0021);
        bus_wr(16'hFF00, 16'h0045);
        bus_rd(16'hFF01);
        check("st_ovf", mem_rdata_o, 16'h0025);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_vld", tx_valid_o, 1'b1);
            check("drain_byte", tx_data_o, 8'h41 + 8'(i));
            bus_idle();
        end
        bus_rd(16'hFF01);
        check("st_empty_ovf", mem_rdata_o, 16'h0006);
        bus_wr(16'hFF01, 16'h0004);
        bus_rd(16'hFF01);
        check("st_clr", mem_rdata_o, 16'h0002);
        step(16'hFF00, 1'b1, 16'hFF00, 16'h0077, 1'b1);
        check("st_prepush", mem_rdata_o, 16'h0002);
        bus_idle();

        // Push into a full FIFO while it pops
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) bus_wr(16'hFF00, 16'h0051 + 16'(i));
        rdy = 1'b1;
        check("fp_head", tx_data_o, 8'h51);
        bus_wr(16'hFF00, 16'h0055);
        rdy = 1'b0;
        bus_rd(16'hFF01);
        check("fp_status", mem_rdata_o, 16'h0021);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fp_byte", tx_data_o, 8'h52 + 8'(i));
            bus_idle();
        end
        check("fp_empty", tx_valid_o, 1'b0);

        // Asynchronous reset mid-stream
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) bus_wr(16'hFF00, 16'h0061 + 16'(i));
        bus_wr(16'hFF04, 16'h00A5);
        check("led_set", led_o, 8'hA5);
        bus_rd(16'h0010);
        check("pre_rst_rd", mem_rdata_o, 16'h1234);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", tx_valid_o, 1'b0);
        check("arst_led", led_o, 8'h00);
        check("arst_rdata", mem_rdata_o, 16'h0000);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(16'hFF01);
        check("post_rst_st", mem_rdata_o, 16'h0002);
        bus_rd(16'h0010);
        check("ram_kept", mem_rdata_o, 16'h1234);

        // Counter snapshot across the 16-bit boundary and after a long run
        while (m_cnt != 32'h0000FFFF) bus_idle();
        bus_rd(16'hFF02);
        check("cnt_lo_ffff", mem_rdata_o, 16'hFFFF);
        bus_rd(16'hFF03);
        check("cnt_hi_0", mem_rdata_o, 16'h0000);
        bus_rd(16'hFF02);
        check("cnt_lo_1", mem_rdata_o, 16'h0001);
        bus_rd(16'hFF03);
        check("cnt_hi_1", mem_rdata_o, 16'h0001);
        while (m_cnt < 32'd70000) bus_idle();
        exp_cnt = m_cnt;
        bus_rd(16'hFF02);
        lo = mem_rdata_o;
        bus_rd(16'hFF03);
        check("cnt_70k", {mem_rdata_o, lo}, exp_cnt);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rdy = 1'($urandom_range(0, 1));
            ra = pick_addr();
            wa = pick_addr();
            step(ra, 1'($urandom_range(0, 1)), wa, 16'($urandom), $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_target.md
Name: cpu_bus_target

Overview:
Memory-side responder for the CPU's split read/write memory bus. It answers instruction fetches, loads and stores with exact one-cycle read latency, because the bus has no wait signal. It contains a word RAM and a small MMIO block: a byte-wide TX stream FIFO, a 32-bit cycle counter with a coherent snapshot, and an LED register. It sits directly between the CPU ports and on-chip memory/peripherals.

Parameters:
RAM_AWIDTH, 12, RAM word-address width; RAM occupies 0x0000..2^RAM_AWIDTH-1 (RAM_AWIDTH <= 15).
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..8.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
mem_raddr_i  input  16  read word address from CPU.
mem_rd_i  input  1  read strobe (CPU holds it at 1).
mem_rdata_o  output  16  read data, registered, valid the cycle after the address.
mem_waddr_i  input  16  write word address.
mem_wdata_i  input  16  write data.
mem_wr_i  input  1  write strobe; write commits at this rising edge.
tx_valid_o  output  1  FIFO head valid.
tx_data_o  output  8  FIFO head byte.
tx_ready_i  input  1  sink accepts head when tx_valid_o & tx_ready_i.
led_o  output  8  LED register.

Behaviour:
- Reset (async, rst_n=0): mem_rdata_o=0, tx_valid_o=0, tx_data_o=0, led_o=0; FIFO empty, overflow flag=0, counter=0, snapshot=0. RAM contents are not cleared. Deassertion is released on a clk edge.
- Address map (read and write): RAM for addr < 2^RAM_AWIDTH. IO page 0xFF00..0xFFFF, decoded on addr[2:0] with addr[7:3]=0, otherwise unmapped. Everything else is unmapped: reads return 0, writes are ignored.
- Read: on each edge with mem_rd_i=1, mem_rdata_o <= data(mem_raddr_i). With mem_rd_i=0, mem_rdata_o holds.
- Write: on each edge with mem_wr_i=1, target(mem_waddr_i) <= mem_wdata_i.
- Same-cycle read and write to the same address returns OLD data (read-before-write). The new value is visible from the next read.
- IO registers:
  - 0xFF00 TXDATA. Write pushes mem_wdata_i[7:0]. Read returns the status word.
  - 0xFF01 STATUS, read: bit0 full, bit1 empty, bit2 overflow, bits[6:3] count, rest 0. Writing 1 to bit2 clears overflow.
  - 0xFF02 CNTLO. Read returns counter[15:0] at that edge; the same edge latches snapshot <= counter[31:16].
  - 0xFF03 CNTHI. Read returns snapshot.
  - 0xFF04 LED. Read/write led_o from/to data[7:0]; read bits[15:8]=0.
  - 0xFF05..0xFF07 read 0; writes ignored.
- Status reads show pre-edge state. A push and a status read in the same cycle return the state before the push.
- Counter: 32-bit, increments every cycle out of reset, wraps 0xFFFFFFFF->0. Writes are ignored.
- FIFO:
  - Pop when tx_valid_o & tx_ready_i.
  - Push is accepted if not full, or if full with a pop in the same cycle (count unchanged).
  - Push while full and no pop: byte dropped, overflow <= 1 (sticky).
  - Push into empty: tx_valid_o rises the next cycle; there is no combinational input-to-output path.
  - tx_data_o and tx_valid_o are stable while tx_valid_o=1 and tx_ready_i=0.
  - Pointers wrap modulo FIFO_DEPTH. Count is 0..FIFO_DEPTH.
- An overflow clear (write STATUS bit2) and an overflow-setting push cannot both occur in one cycle, since there is a single write port.
- Reset asserted mid-transfer drops all queued bytes. tx_valid_o falls asynchronously.

Test Plan:
- Write RAM 0x0010=0xBEEF; next cycle raddr=0x0010 -> mem_rdata_o=0xBEEF one cycle later. Same-cycle write 0x1234 to 0x0010 with read of 0x0010 -> returns 0xBEEF, following read 0x1234.
- Read 0x8000 and 0xFF10 -> 0x0000; write to 0x8000 then read back -> 0x0000; RAM unchanged.
- tx_ready_i=0; push 0x41,0x42,0x43,0x44,0x45 -> STATUS=0x0021 (count 4, full), then after fifth push 0x0025 (overflow set); tx_ready_i=1 -> bytes 0x41..0x44 in order, then STATUS=0x0006; write 0x0004 to STATUS -> 0x0002.
- FIFO full with tx_ready_i=1, push 0x55 -> count stays 4, no overflow, 0x55 emerges fifth.
- Run 70000 cycles; read CNTLO then CNTHI -> combined value equals counter at the CNTLO edge, including across the 0x0000FFFF->0x00010000 boundary.
- Queue 3 bytes, write LED=0xA5, pulse rst_n low mid-stream -> immediately tx_valid_o=0, led_o=0, mem_rdata_o=0; STATUS=0x0002 after release; RAM 0x0010 still reads 0x1234.
